axi_stream_packet_source: RTL and testbench

//  Parametrised AXI4-Stream source feeding the PolarFire SoC DMA. Packs IN_WIDTH-bit input

---
 rtl/axi_stream_packet_source_if.sv | 26 ++
 rtl/axi_stream_packet_source.sv | 163 ++++++++++++++++
 tb/tb_axi_stream_packet_source.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_packet_source_if.sv
// AXI4-Stream bundle between the packet source (master) and the DMA stream slave.
// TDATA width follows OUT_BYTES so one interface type serves every source configuration.
interface axi_stream_packet_source_if #(
   parameter int OUT_BYTES = 4
);
   localparam int TDATA_W = 8 * OUT_BYTES;

   logic                 tvalid;
   logic                 tready;
   logic [TDATA_W-1:0]   tdata;
   logic                 tlast;
   logic [OUT_BYTES-1:0] tkeep;
   logic [OUT_BYTES-1:0] tstrb;
   logic [7:0]           tid;
   logic [1:0]           tdest;

   modport master (
      output tvalid, tdata, tlast, tkeep, tstrb, tid, tdest,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tlast, tkeep, tstrb, tid, tdest,
      output tready
   );
endinterface

// File: rtl/axi_stream_packet_source.sv
// Packs IN_WIDTH-bit slices (pins or counter pattern) into AXI4-Stream words, buffers them in
// a first-word-fall-through FIFO and frames them into packets of runtime length with TLAST.
module axi_stream_packet_source #(
   parameter int         IN_WIDTH        = 8,
   parameter int         OUT_BYTES       = 4,
   parameter int         FIFO_DEPTH_BITS = 4,
   parameter int         PKT_LEN_W       = 16,
   parameter logic [7:0] TID_VAL         = 8'h00,
   parameter logic [1:0] TDEST_VAL       = 2'b00
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       enable,
   input  logic                       mode,
   input  logic [PKT_LEN_W-1:0]       pkt_len,
   input  logic [IN_WIDTH-1:0]        data_pins,
   input  logic                       pins_valid,
   output logic                       pins_ready,
   axi_stream_packet_source_if.master m_axis,
   output logic [FIFO_DEPTH_BITS:0]   fifo_level,
   output logic                       pkt_done
);
   localparam int TDATA_W = 8 * OUT_BYTES;
   localparam int RATIO   = TDATA_W / IN_WIDTH;
   localparam int CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int DEPTH   = 2 ** FIFO_DEPTH_BITS;

   localparam logic [CNT_W-1:0]           LAST_SLICE = CNT_W'(RATIO - 1);
   localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
   localparam logic [IN_WIDTH-1:0]        PAT_ONE    = IN_WIDTH'(1);
   localparam logic [PKT_LEN_W-1:0]       LEN_ONE    = PKT_LEN_W'(1);
   localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE    = FIFO_DEPTH_BITS'(1);
   localparam logic [FIFO_DEPTH_BITS:0]   LVL_ONE    = (FIFO_DEPTH_BITS + 1)'(1);
   localparam logic [FIFO_DEPTH_BITS:0]   LVL_FULL   = (FIFO_DEPTH_BITS + 1)'(DEPTH);

   logic [CNT_W-1:0]           slice_cnt_r;
   logic [TDATA_W-1:0]         acc_r;
   logic                       cur_mode_r;
   logic [IN_WIDTH-1:0]        pat_r;
   logic [PKT_LEN_W-1:0]       word_cnt_r;
   logic [PKT_LEN_W-1:0]       len_lat_r;
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
   logic [FIFO_DEPTH_BITS:0]   level_r;
   logic                       pkt_done_r;
   logic [TDATA_W:0]           mem_r [DEPTH];

   logic                 eff_mode_s;
   logic                 last_slice_s;
   logic                 room_s;
   logic                 take_s;
   logic                 wr_s;
   logic                 rd_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 tlast_s;
   logic [IN_WIDTH-1:0]  slice_s;
   logic [TDATA_W-1:0]   word_s;
   logic [PKT_LEN_W-1:0] len_eff_s;
   logic [TDATA_W:0]     head_s;

   // Slice acceptance, word assembly and packet framing for the word being built.
   always_comb begin
      full_s       = (level_r == LVL_FULL);
      empty_s      = (level_r == '0);
      // The source is chosen at the first slice of a word and then held, so words never mix.
      eff_mode_s   = (slice_cnt_r == '0) ? mode : cur_mode_r;
      slice_s      = eff_mode_s ? pat_r : data_pins;
      last_slice_s = (slice_cnt_r == LAST_SLICE);
      // Full FIFO only blocks the completing slice; a same-cycle read does not unblock it.
      room_s       = !last_slice_s || !full_s;
      pins_ready   = !areset && enable && !eff_mode_s && room_s;
      take_s       = !areset && enable && (eff_mode_s || pins_valid) && room_s;
      wr_s         = take_s && last_slice_s;
      word_s       = acc_r;
      word_s[slice_cnt_r * IN_WIDTH +: IN_WIDTH] = slice_s;
      len_eff_s    = (word_cnt_r == '0) ? pkt_len : len_lat_r;
      tlast_s      = (len_eff_s != '0) && (word_cnt_r == (len_eff_s - LEN_ONE));
      head_s       = mem_r[rd_ptr_r];
      rd_s         = !empty_s && m_axis.tready;
   end

   // Packing, pattern, framing counters, FIFO pointers/level and pkt_done pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         slice_cnt_r <= '0;
         acc_r       <= '0;
         cur_mode_r  <= 1'b0;
         pat_r       <= '0;
         word_cnt_r  <= '0;
         len_lat_r   <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         level_r     <= '0;
         pkt_done_r  <= 1'b0;
      end else begin
         cur_mode_r <= eff_mode_s;
         if (take_s) begin
            slice_cnt_r <= last_slice_s ? '0 : (slice_cnt_r + CNT_ONE);
            acc_r       <= last_slice_s ? '0 : word_s;
            pat_r       <= eff_mode_s ? (pat_r + PAT_ONE) : pat_r;
         end
         if (wr_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            len_lat_r  <= len_eff_s;
            word_cnt_r <= (tlast_s || (len_eff_s == '0)) ? '0 : (word_cnt_r + LEN_ONE);
         end
         if (rd_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_s, rd_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
         pkt_done_r <= rd_s && head_s[TDATA_W];
      end
   end

   // FIFO storage; entries are {tlast, tdata} and need no reset.
   always_ff @(posedge aclk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {tlast_s, word_s};
      end
   end

   assign m_axis.tvalid = !empty_s;
   assign m_axis.tdata  = head_s[TDATA_W-1:0];
   assign m_axis.tlast  = !empty_s && head_s[TDATA_W];
   assign m_axis.tkeep  = {OUT_BYTES{1'b1}};
   assign m_axis.tstrb  = {OUT_BYTES{1'b1}};
   assign m_axis.tid    = TID_VAL;
   assign m_axis.tdest  = TDEST_VAL;
   assign fifo_level    = level_r;
   assign pkt_done      = pkt_done_r;

   axi_stream_packet_source_chk u_chk (
      .aclk   (aclk),
      .areset (areset),
      .wr     (wr_s),
      .full   (full_s),
      .rd     (rd_s),
      .empty  (empty_s)
   );
endmodule

// FIFO protocol checker: the source must never write a full or read an empty FIFO.
module axi_stream_packet_source_chk (
   input logic aclk,
   input logic areset,
   input logic wr,
   input logic full,
   input logic rd,
   input logic empty
);
   // Sampled each clock outside reset.
   always @(posedge aclk) begin
      if (!areset) begin
         assert (!(wr && full)) else $error("axi_stream_packet_source: write while full");
         assert (!(rd && empty)) else $error("axi_stream_packet_source: read while empty");
      end
   end
endmodule

// File: tb/tb_axi_stream_packet_source.sv
// Directed bench for axi_stream_packet_source: default 8->32 packer plus 16->32 and 32->32 builds.
module tb_axi_stream_packet_source;
   logic        aclk;
   logic        areset;
   logic        enable;
   logic        mode;
   logic [15:0] pkt_len;
   logic [7:0]  data_pins;
   logic        pins_valid;
   logic        pins_ready;
   logic [4:0]  fifo_level;
   logic        pkt_done;

   logic        en16, v16, rdy16, done16;
   logic [15:0] d16;
   logic [4:0]  lvl16;
   logic        en32, v32, rdy32, done32;
   logic [31:0] d32;
   logic [4:0]  lvl32;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int max_level = 0;
   logic [32:0] words_q [$];

   axi_stream_packet_source_if #(.OUT_BYTES(4)) axs ();
   axi_stream_packet_source_if #(.OUT_BYTES(4)) axs16 ();
   axi_stream_packet_source_if #(.OUT_BYTES(4)) axs32 ();

   axi_stream_packet_source dut (
      .aclk(aclk), .areset(areset), .enable(enable), .mode(mode), .pkt_len(pkt_len),
      .data_pins(data_pins), .pins_valid(pins_valid), .pins_ready(pins_ready),
      .m_axis(axs), .fifo_level(fifo_level), .pkt_done(pkt_done)
   );

   axi_stream_packet_source #(.IN_WIDTH(16)) dut16 (
      .aclk(aclk), .areset(areset), .enable(en16), .mode(mode), .pkt_len(pkt_len),
      .data_pins(d16), .pins_valid(v16), .pins_ready(rdy16),
      .m_axis(axs16), .fifo_level(lvl16), .pkt_done(done16)
   );

   axi_stream_packet_source #(.IN_WIDTH(32)) dut32 (
      .aclk(aclk), .areset(areset), .enable(en32), .mode(mode), .pkt_len(pkt_len),
      .data_pins(d32), .pins_valid(v32), .pins_ready(rdy32),
      .m_axis(axs32), .fifo_level(lvl32), .pkt_done(done32)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Records handshaken words, pkt_done pulses and peak level of the main DUT.
   always @(negedge aclk) begin
      if (axs.tvalid && axs.tready) words_q.push_back({axs.tlast, axs.tdata});
      if (pkt_done) done_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic do_reset();
      areset = 1'b1;
      tick(2);
      areset = 1'b0;
      words_q.delete();
      done_cnt = 0;
      max_level = 0;
   endtask

   task automatic push_slice(input logic [7:0] v);
      bit ok;
      ok = 1'b0;
      data_pins = v;
      pins_valid = 1'b1;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge aclk);
         ok = pins_ready;
         @(posedge aclk);
         #1;
      end
      pins_valid = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL push_slice accepted=%0b required=1 slice=%h", ok, v);
      end
   endtask

   task automatic wait_words(input int n);
      for (int c = 0; c < 400 && words_q.size() < n; c++) tick(1);
   endtask

   task automatic test_reset();
      areset = 1'b1;
      enable = 1'b1;
      pins_valid = 1'b1;
      tick(2);
      @(negedge aclk);
      checks++; if (pins_ready !== 1'b0) begin errors++; $display("FAIL rst_pins_ready got %b exp 0", pins_ready); end
      checks++; if (axs.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", axs.tvalid); end
      checks++; if (axs.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", axs.tlast); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got %b exp 0", pkt_done); end
      checks++; if ({axs.tkeep, axs.tstrb} !== 8'hFF) begin errors++; $display("FAIL rst_keep_strb got %h exp ff", {axs.tkeep, axs.tstrb}); end
      checks++; if ({axs.tid, axs.tdest} !== 10'd0) begin errors++; $display("FAIL rst_id_dest got %h exp 0", {axs.tid, axs.tdest}); end
      tick(1);
      enable = 1'b0;
      pins_valid = 1'b0;
      do_reset();
   endtask

   task automatic test_pins_packet();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
      exp_w[2] = 32'h0C0B0A09; exp_w[3] = 32'h100F0E0D;
      do_reset();
      mode = 1'b0; pkt_len = 16'd4; enable = 1'b1; axs.tready = 1'b1;
      for (int i = 1; i <= 16; i++) push_slice(8'(i));
      wait_words(4);
      tick(3);
      checks++; if (words_q.size() !== 4) begin errors++; $display("FAIL t1_count got %0d exp 4", words_q.size()); end
      if (words_q.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (words_q[k] !== {(k == 3), exp_w[k]}) begin
               errors++; $display("FAIL t1_word%0d got %h exp %h", k, words_q[k], {(k == 3), exp_w[k]});
            end
         end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1_pkt_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_pins_stall();
      do_reset();
      mode = 1'b0; pkt_len = 16'd0; enable = 1'b1; axs.tready = 1'b0;
      data_pins = 8'h55; pins_valid = 1'b1;
      tick(80);
      @(negedge aclk);
      checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL stall_level got %0d exp 16", fifo_level); end
      checks++; if (pins_ready !== 1'b0) begin errors++; $display("FAIL stall_pins_ready got %b exp 0", pins_ready); end
      tick(1);
      pins_valid = 1'b0; enable = 1'b0; axs.tready = 1'b1;
      tick(20);
      checks++; if (words_q.size() !== 16) begin errors++; $display("FAIL stall_drained got %0d exp 16", words_q.size()); end
      checks++; if (max_level !== 16) begin errors++; $display("FAIL stall_max_level got %0d exp 16", max_level); end
   endtask

   task automatic test_pattern_backpressure();
      logic [32:0] exp;
      bit bad;
      do_reset();
      mode = 1'b1; pkt_len = 16'd0; enable = 1'b1; axs.tready = 1'b0;
      tick(80);
      @(negedge aclk);
      checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL t2_level got %0d exp 16", fifo_level); end
      checks++; if (words_q.size() !== 0) begin errors++; $display("FAIL t2_no_reads got %0d exp 0", words_q.size()); end
      tick(1);
      axs.tready = 1'b1;
      wait_words(20);
      enable = 1'b0;
      checks++; if (words_q.size() < 20) begin errors++; $display("FAIL t2_count got %0d exp >=20", words_q.size()); end
      if (words_q.size() >= 20) begin
         bad = 1'b0;
         for (int k = 0; k < 20; k++) begin
            exp = {1'b0, 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            checks++;
            if (words_q[k] !== exp) begin
               errors++; $display("FAIL t2_word%0d got %h exp %h", k, words_q[k], exp);
            end
         end
      end
      checks++; if (max_level !== 16) begin errors++; $display("FAIL t2_max_level got %0d exp 16", max_level); end
   endtask

   task automatic test_widths();
      do_reset();
      mode = 1'b0; pkt_len = 16'd1;
      en16 = 1'b1; v16 = 1'b1; d16 = 16'h1111; axs16.tready = 1'b0;
      en32 = 1'b1; v32 = 1'b1; d32 = 32'hDEADBEEF; axs32.tready = 1'b0;
      tick(1);
      v32 = 1'b0; d16 = 16'h2222;
      tick(1);
      v16 = 1'b0;
      @(negedge aclk);
      checks++; if ({axs16.tvalid, axs16.tlast, axs16.tdata} !== {2'b11, 32'h22221111}) begin
         errors++; $display("FAIL t3_w16 got %b%b %h exp 11 22221111", axs16.tvalid, axs16.tlast, axs16.tdata);
      end
      checks++; if (lvl16 !== 5'd1) begin errors++; $display("FAIL t3_w16_level got %0d exp 1", lvl16); end
      checks++; if ({axs32.tvalid, axs32.tlast, axs32.tdata} !== {2'b11, 32'hDEADBEEF}) begin
         errors++; $display("FAIL t3_w32 got %b%b %h exp 11 deadbeef", axs32.tvalid, axs32.tlast, axs32.tdata);
      end
      tick(1);
      en16 = 1'b0; en32 = 1'b0; axs16.tready = 1'b1; axs32.tready = 1'b1;
   endtask

   task automatic test_enable_pause();
      do_reset();
      mode = 1'b0; pkt_len = 16'd0; enable = 1'b1; axs.tready = 1'b1;
      push_slice(8'hA1);
      push_slice(8'hA2);
      enable = 1'b0; mode = 1'b1;
      tick(2);
      @(negedge aclk);
      checks++; if (pins_ready !== 1'b0) begin errors++; $display("FAIL t4_paused_ready got %b exp 0", pins_ready); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t4_paused_level got %0d exp 0", fifo_level); end
      tick(3);
      enable = 1'b1;
      push_slice(8'hA3);
      push_slice(8'hA4);
      wait_words(2);
      enable = 1'b0;
      checks++; if (words_q.size() < 2) begin errors++; $display("FAIL t4_count got %0d exp >=2", words_q.size()); end
      if (words_q.size() >= 2) begin
         checks++; if (words_q[0] !== {1'b0, 32'hA4A3A2A1}) begin errors++; $display("FAIL t4_pins_word got %h exp 0a4a3a2a1", words_q[0]); end
         checks++; if (words_q[1] !== {1'b0, 32'h03020100}) begin errors++; $display("FAIL t4_pattern_word got %h exp 003020100", words_q[1]); end
      end
   endtask

   task automatic test_len_change();
      logic [32:0] exp;
      do_reset();
      mode = 1'b0; pkt_len = 16'd3; enable = 1'b1; axs.tready = 1'b1;
      for (int i = 1; i <= 4; i++) push_slice(8'(i));
      pkt_len = 16'd2;
      for (int i = 5; i <= 20; i++) push_slice(8'(i));
      wait_words(5);
      tick(3);
      checks++; if (words_q.size() !== 5) begin errors++; $display("FAIL t5_count got %0d exp 5", words_q.size()); end
      if (words_q.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            exp = {(k == 2 || k == 4), 8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
            checks++;
            if (words_q[k] !== exp) begin
               errors++; $display("FAIL t5_word%0d got %h exp %h", k, words_q[k], exp);
            end
         end
      end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL t5_pkt_done got %0d exp 2", done_cnt); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      mode = 1'b0; pkt_len = 16'd3; enable = 1'b1; axs.tready = 1'b0;
      for (int i = 1; i <= 34; i++) push_slice(8'(i));
      @(negedge aclk);
      checks++; if (fifo_level !== 5'd8) begin errors++; $display("FAIL t6_pre_level got %0d exp 8", fifo_level); end
      tick(1);
      areset = 1'b1;
      tick(1);
      areset = 1'b0;
      @(negedge aclk);
      checks++; if (axs.tvalid !== 1'b0) begin errors++; $display("FAIL t6_tvalid got %b exp 0", axs.tvalid); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL t6_level got %0d exp 0", fifo_level); end
      tick(1);
      words_q.delete();
      axs.tready = 1'b1;
      push_slice(8'hB1); push_slice(8'hB2); push_slice(8'hB3); push_slice(8'hB4);
      wait_words(1);
      tick(2);
      checks++; if (words_q.size() !== 1) begin errors++; $display("FAIL t6_count got %0d exp 1", words_q.size()); end
      if (words_q.size() >= 1) begin
         checks++; if (words_q[0] !== {1'b0, 32'hB4B3B2B1}) begin errors++; $display("FAIL t6_word got %h exp 0b4b3b2b1", words_q[0]); end
      end
   endtask

   initial begin
      areset = 1'b1; enable = 1'b0; mode = 1'b0; pkt_len = 16'd0;
      data_pins = 8'h00; pins_valid = 1'b0; axs.tready = 1'b0;
      en16 = 1'b0; v16 = 1'b0; d16 = 16'h0000; axs16.tready = 1'b0;
      en32 = 1'b0; v32 = 1'b0; d32 = 32'h0; axs32.tready = 1'b0;
      test_reset();
      test_pins_packet();
      test_pins_stall();
      test_pattern_backpressure();
      test_widths();
      test_enable_pause();
      test_len_change();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
